// File: rtl/mini_aes_iter.sv
// Iterative 16-bit mini-AES (nibble S-AES) engine: one round per clock, key
// schedule expanded once per key into a round-key file, encrypt and decrypt.
module mini_aes_iter #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [15:0] key,
  output logic        key_ready,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  input  logic        in_decrypt,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {IDLE, KEY_EXP, READY, RUN, DONE} state_e;

  state_e      st_q;
  logic [3:0]  round_q;
  logic [3:0]  rc_q;
  logic        dec_q;
  logic [15:0] out_data_q;
  logic [15:0] blk_q;
  logic [15:0] rk_q [16];

  logic [15:0] enc_d, dec_d, blk_d, key_d;
  logic        last_round;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    case (n)
      4'h0: sbox = 4'h9;  4'h1: sbox = 4'h4;  4'h2: sbox = 4'hA;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'hD;  4'h5: sbox = 4'h1;  4'h6: sbox = 4'h8;  4'h7: sbox = 4'h5;
      4'h8: sbox = 4'h6;  4'h9: sbox = 4'h2;  4'hA: sbox = 4'h0;  4'hB: sbox = 4'h3;
      4'hC: sbox = 4'hC;  4'hD: sbox = 4'hE;  4'hE: sbox = 4'hF;  default: sbox = 4'h7;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    case (n)
      4'h0: inv_sbox = 4'hA;  4'h1: inv_sbox = 4'h5;  4'h2: inv_sbox = 4'h9;  4'h3: inv_sbox = 4'hB;
      4'h4: inv_sbox = 4'h1;  4'h5: inv_sbox = 4'h7;  4'h6: inv_sbox = 4'h8;  4'h7: inv_sbox = 4'hF;
      4'h8: inv_sbox = 4'h6;  4'h9: inv_sbox = 4'h0;  4'hA: inv_sbox = 4'h2;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'hC;  4'hD: inv_sbox = 4'h4;  4'hE: inv_sbox = 4'hD;  default: inv_sbox = 4'hE;
    endcase
  endfunction

  // Multiply by x modulo x^4+x+1: the carried-out x^4 folds back as x+1.
  function automatic logic [3:0] xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ {2'b00, a[3], a[3]};
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [15:0] sub_word(input logic [15:0] w);
    return {sbox(w[15:12]), sbox(w[11:8]), sbox(w[7:4]), sbox(w[3:0])};
  endfunction

  function automatic logic [15:0] inv_sub_word(input logic [15:0] w);
    return {inv_sbox(w[15:12]), inv_sbox(w[11:8]), inv_sbox(w[7:4]), inv_sbox(w[3:0])};
  endfunction

  function automatic logic [15:0] shift_row(input logic [15:0] w);
    return {w[15:12], w[3:0], w[7:4], w[11:8]};
  endfunction

  function automatic logic [15:0] mix_col(input logic [15:0] w);
    return {w[15:12] ^ gf_mul(4'h4, w[11:8]), gf_mul(4'h4, w[15:12]) ^ w[11:8],
            w[7:4] ^ gf_mul(4'h4, w[3:0]),    gf_mul(4'h4, w[7:4]) ^ w[3:0]};
  endfunction

  function automatic logic [15:0] inv_mix_col(input logic [15:0] w);
    return {gf_mul(4'h9, w[15:12]) ^ gf_mul(4'h2, w[11:8]),
            gf_mul(4'h2, w[15:12]) ^ gf_mul(4'h9, w[11:8]),
            gf_mul(4'h9, w[7:4]) ^ gf_mul(4'h2, w[3:0]),
            gf_mul(4'h2, w[7:4]) ^ gf_mul(4'h9, w[3:0])};
  endfunction

  function automatic logic [15:0] key_step(input logic [15:0] k, input logic [3:0] rc);
    logic [7:0] w2;
    w2 = k[15:8] ^ {rc, 4'h0} ^ {sbox(k[3:0]), sbox(k[7:4])};
    return {w2, w2 ^ k[7:0]};
  endfunction

  assign key_ready = (st_q == IDLE) || (st_q == READY);
  assign in_ready  = (st_q == READY) && !key_valid;
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q == KEY_EXP) || (st_q == RUN) || (st_q == DONE);
  assign out_data  = out_data_q;

  // round_q doubles as the key-file index while expanding.
  always_comb begin
    enc_d = shift_row(sub_word(blk_q));
    if (round_q != LAST) enc_d = mix_col(enc_d);
    enc_d = enc_d ^ rk_q[round_q];

    dec_d = inv_sub_word(shift_row(blk_q)) ^ rk_q[round_q - 4'd1];
    if (round_q != 4'd1) dec_d = inv_mix_col(dec_d);

    blk_d      = dec_q ? dec_d : enc_d;
    last_round = dec_q ? (round_q == 4'd1) : (round_q == LAST);
    key_d      = key_step(rk_q[round_q - 4'd1], rc_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      round_q    <= 4'd0;
      rc_q       <= 4'h0;
      dec_q      <= 1'b0;
      out_data_q <= 16'h0000;
    end else begin
      case (st_q)
        IDLE, READY: begin
          if (key_valid) begin
            round_q <= 4'd1;
            rc_q    <= 4'h8;
            st_q    <= KEY_EXP;
          end else if (st_q == READY && in_valid) begin
            dec_q   <= in_decrypt;
            round_q <= in_decrypt ? LAST : 4'd1;
            st_q    <= RUN;
          end
        end
        KEY_EXP: begin
          rc_q <= xtime(rc_q);
          if (round_q == LAST) st_q <= READY;
          else                 round_q <= round_q + 4'd1;
        end
        RUN: begin
          if (last_round) begin
            out_data_q <= blk_d;
            st_q       <= DONE;
          end else begin
            round_q <= dec_q ? round_q - 4'd1 : round_q + 4'd1;
          end
        end
        DONE: if (out_ready) st_q <= READY;
        default: st_q <= IDLE;
      endcase
    end
  end

  // Key file and cipher state carry no reset; a reset returns to IDLE, which
  // forces a fresh key load before any of this content is used again.
  always_ff @(posedge clk) begin
    if (key_ready && key_valid) rk_q[0] <= key;
    if (st_q == KEY_EXP)        rk_q[round_q] <= key_d;
    if (in_ready && in_valid)
      blk_q <= in_data ^ (in_decrypt ? rk_q[LAST] : rk_q[0]);
    else if (st_q == RUN)
      blk_q <= blk_d;
  end

endmodule
